// File: rtl/cpu_clk_en_ctrl.sv
// cpu_clk_en_ctrl: single-clock enable generator for the 4004-style core.
// The core stays on the board clock and advances only while cpuClkEn is high.
// Modes: STEP (one enable per button press), BURST (BURST_LEN paced enables
// per press), RATE (divided rate) and FULL (every cycle).
// Optional PC breakpoint halt: define CLKCTRL_BREAKPOINT_EN to build it in.
module cpu_clk_en_ctrl #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [23:0] RATE_MAX0  = 24'd5999999,
    parameter logic [23:0] RATE_MAX1  = 24'd599999,
    parameter logic [23:0] RATE_MAX2  = 24'd59999,
    parameter logic [23:0] RATE_MAX3  = 24'd5999,
    parameter logic [7:0]  BURST_LEN  = 8'd16,
    parameter int          ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              stepBtn,
    input  logic [1:0]        modeSel,
    input  logic [1:0]        rateSel,
    input  logic              bpEn,
    input  logic [ADDR_W-1:0] bpAddr,
    input  logic [ADDR_W-1:0] pcAddr,
    output logic              cpuClkEn,
    output logic              halted,
    output logic              busy
);

    localparam logic [1:0] MODE_STEP  = 2'b00;
    localparam logic [1:0] MODE_BURST = 2'b01;
    localparam logic [1:0] MODE_RATE  = 2'b10;
    localparam logic [1:0] MODE_FULL  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BURST = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    logic        sync1_r;
    logic        sync2_r;
    logic        deb_r;
    logic        deb_prev_r;
    logic [15:0] deb_cnt_r;
    logic        press_s;

    logic [23:0] div_cnt_r;
    logic [1:0]  rate_prev_r;
    logic [23:0] rate_max_s;
    logic        rate_chg_s;
    logic        tick_s;

    state_t      state_r;
    logic [7:0]  burst_cnt_r;
    logic        cpu_clk_en_r;
    logic        halted_r;
    logic        busy_r;
    logic        chk_r;
    logic        bp_hit_s;

    // Two-flop synchronizer for the asynchronous, active-low button.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= stepBtn;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: follow the synchronized input only after DEB_CYCLES
    // consecutive samples that disagree with the current output.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            deb_r      <= 1'b1;
            deb_prev_r <= 1'b1;
            deb_cnt_r  <= 16'd0;
        end else begin
            deb_prev_r <= deb_r;
            if (sync2_r != deb_r) begin
                if (deb_cnt_r == (DEB_CYCLES - 16'd1)) begin
                    deb_r     <= sync2_r;
                    deb_cnt_r <= 16'd0;
                end else begin
                    deb_cnt_r <= deb_cnt_r + 16'd1;
                end
            end else begin
                deb_cnt_r <= 16'd0;
            end
        end
    end

    // A press is the falling edge of the debounced button; release is ignored.
    assign press_s = deb_prev_r & ~deb_r;

    // Terminal count for the currently selected rate.
    always_comb begin
        rate_max_s = RATE_MAX0;
        case (rateSel)
            2'd0:    rate_max_s = RATE_MAX0;
            2'd1:    rate_max_s = RATE_MAX1;
            2'd2:    rate_max_s = RATE_MAX2;
            2'd3:    rate_max_s = RATE_MAX3;
            default: rate_max_s = RATE_MAX0;
        endcase
    end

    assign rate_chg_s = (rateSel != rate_prev_r);
    // A rate change kills the tick of the cycle in which it is seen, so a
    // stale count can never produce an enable at the new rate.
    assign tick_s     = (div_cnt_r == rate_max_s) & ~rate_chg_s;

    // Free-running divider; restarts from zero whenever rateSel changes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt_r   <= 24'd0;
            rate_prev_r <= 2'd0;
        end else begin
            rate_prev_r <= rateSel;
            if (rate_chg_s) begin
                div_cnt_r <= 24'd0;
            end else if (div_cnt_r >= rate_max_s) begin
                div_cnt_r <= 24'd0;
            end else begin
                div_cnt_r <= div_cnt_r + 24'd1;
            end
        end
    end

`ifdef CLKCTRL_BREAKPOINT_EN
    // chk_r marks the cycle after an issued enable, when pcAddr is the new PC.
    assign bp_hit_s = chk_r & bpEn & (pcAddr == bpAddr);
    assign halted   = halted_r;
`else
    assign bp_hit_s = 1'b0;
    assign halted   = 1'b0;
    logic unused_bp_s;
    assign unused_bp_s = ^{chk_r, halted_r, bpEn, bpAddr, pcAddr};
`endif

    // Control FSM with registered enable, halted and busy outputs.
    // A breakpoint hit takes priority over everything, including a press.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= ST_RUN;
            burst_cnt_r  <= 8'd0;
            cpu_clk_en_r <= 1'b0;
            halted_r     <= 1'b0;
            busy_r       <= 1'b0;
            chk_r        <= 1'b0;
        end else begin
            chk_r <= cpu_clk_en_r;
            case (state_r)
                ST_RUN: begin
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                    if (bp_hit_s) begin
                        state_r      <= ST_HALT;
                        halted_r     <= 1'b1;
                        cpu_clk_en_r <= 1'b0;
                    end else begin
                        case (modeSel)
                            MODE_STEP: cpu_clk_en_r <= press_s;
                            MODE_BURST: begin
                                cpu_clk_en_r <= 1'b0;
                                if (press_s) begin
                                    state_r     <= ST_BURST;
                                    burst_cnt_r <= BURST_LEN;
                                    busy_r      <= 1'b1;
                                end else begin
                                    burst_cnt_r <= 8'd0;
                                end
                            end
                            MODE_RATE: cpu_clk_en_r <= tick_s;
                            MODE_FULL: cpu_clk_en_r <= 1'b1;
                            default:   cpu_clk_en_r <= 1'b0;
                        endcase
                    end
                end
                ST_BURST: begin
                    if (bp_hit_s) begin
                        state_r      <= ST_HALT;
                        halted_r     <= 1'b1;
                        busy_r       <= 1'b0;
                        cpu_clk_en_r <= 1'b0;
                        burst_cnt_r  <= 8'd0;
                    end else if ((modeSel != MODE_BURST) || (burst_cnt_r == 8'd0)) begin
                        // Mode change aborts; an empty counter ends the burst.
                        state_r      <= ST_RUN;
                        busy_r       <= 1'b0;
                        cpu_clk_en_r <= 1'b0;
                        burst_cnt_r  <= 8'd0;
                    end else if (tick_s) begin
                        cpu_clk_en_r <= 1'b1;
                        burst_cnt_r  <= burst_cnt_r - 8'd1;
                    end else begin
                        cpu_clk_en_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    busy_r <= 1'b0;
                    if (bp_hit_s) begin
                        cpu_clk_en_r <= 1'b0;
                    end else if (press_s) begin
                        // Step over the breakpoint with exactly one enable.
                        state_r      <= ST_RUN;
                        halted_r     <= 1'b0;
                        cpu_clk_en_r <= 1'b1;
                    end else begin
                        cpu_clk_en_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_RUN;
                    burst_cnt_r  <= 8'd0;
                    cpu_clk_en_r <= 1'b0;
                    halted_r     <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign cpuClkEn = cpu_clk_en_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_cpu_clk_en_ctrl.sv
// Testbench for cpu_clk_en_ctrl: directed scenarios with randomized timing,
// expectations derived from the clock-controller rules (latencies, periods,
// enable counts) and a simple PC model that advances on every enable.
module tb_cpu_clk_en_ctrl;

    localparam int DEB  = 4;
    localparam int RM0  = 9;
    localparam int RM1  = 6;
    localparam int RM2  = 4;
    localparam int RM3  = 2;
    localparam int BLEN = 3;

    logic        clk;
    logic        nrst;
    logic        stepBtn;
    logic [1:0]  modeSel;
    logic [1:0]  rateSel;
    logic        bpEn;
    logic [11:0] bpAddr;
    logic [11:0] pcAddr;
    logic        cpuClkEn;
    logic        halted;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cpu_clk_en_ctrl #(
        .DEB_CYCLES (16'(DEB)),
        .RATE_MAX0  (24'(RM0)),
        .RATE_MAX1  (24'(RM1)),
        .RATE_MAX2  (24'(RM2)),
        .RATE_MAX3  (24'(RM3)),
        .BURST_LEN  (8'(BLEN)),
        .ADDR_W     (12)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .stepBtn  (stepBtn),
        .modeSel  (modeSel),
        .rateSel  (rateSel),
        .bpEn     (bpEn),
        .bpAddr   (bpAddr),
        .pcAddr   (pcAddr),
        .cpuClkEn (cpuClkEn),
        .halted   (halted),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the rising edge; the
    // core model increments the PC when the previous cycle carried an enable.
    task automatic step();
        logic en_prev;
        en_prev = cpuClkEn;
        @(posedge clk);
        #1;
        if (en_prev === 1'b1) pcAddr = pcAddr + 12'd1;
        cyc++;
    endtask

    // Steps until cpuClkEn is seen high; delta = cycles taken, -1 on timeout.
    task automatic wait_pulse(input int limit, output int delta);
        bit found;
        found = 1'b0;
        delta = -1;
        for (int i = 1; i <= limit; i++) begin
            if (!found) begin
                step();
                if (cpuClkEn === 1'b1) begin
                    delta = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int pulses, pulse_at, cnt, d, glen;
        int en_q[$];
        int busy_rise, busy_fall, busy_bad, halt_at, pc5_at, post_en, not_halt;

        nrst    = 1'b0;
        stepBtn = 1'b1;
        modeSel = 2'b00;
        rateSel = 2'b00;
        bpEn    = 1'b0;
        bpAddr  = 12'h005;
        pcAddr  = 12'h000;
        repeat (3) step();
        check("reset_en", int'(cpuClkEn), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_busy", int'(busy), 0);
        nrst = 1'b1;
        repeat (10) step();

        // STEP: button low from cycle 0 for 20 cycles -> one pulse at 3+DEB.
        pulses = 0; pulse_at = -1;
        stepBtn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cpuClkEn === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        check("step_count", pulses, 1);
        check("step_cycle", pulse_at, 3 + DEB);
        stepBtn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
        end
        check("step_release_no_pulse", cnt, 0);

        // Glitch shorter than DEB cycles produces nothing.
        glen = $urandom_range(DEB - 1, 1);
        stepBtn = 1'b0;
        repeat (glen) step();
        stepBtn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
        end
        check("glitch_no_pulse", cnt, 0);

        // RATE, rateSel=0: period RM0+1.
        modeSel = 2'b10;
        wait_pulse(3 * (RM0 + 1), d);
        check("rate_first_found", int'(d > 0), 1);
        for (int k = 0; k < 4; k++) begin
            wait_pulse(3 * (RM0 + 1), d);
            check("rate0_period", d, RM0 + 1);
        end
        // Switch in the cycle where the old count sits at terminal count:
        // that tick is lost and the new rate starts from zero.
        repeat (RM0) step();
        rateSel = 2'd1;
        wait_pulse(3 * (RM0 + 1), d);
        check("rate_switch_first", d, RM1 + 2);
        wait_pulse(3 * (RM0 + 1), d);
        check("rate1_period", d, RM1 + 1);
        d = $urandom_range(RM1, 1);
        repeat (d) step();
        rateSel = 2'd0;
        wait_pulse(3 * (RM0 + 1), d);
        check("rate_switch_back", d, RM0 + 2);

        // BURST: one press -> BLEN enables RM0+1 apart; second press ignored.
        modeSel = 2'b01;
        repeat ($urandom_range(9, 0)) step();
        en_q.delete();
        busy_rise = -1; busy_fall = -1; busy_bad = 0;
        stepBtn = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (cpuClkEn === 1'b1) begin
                en_q.push_back(i);
                if (busy !== 1'b1) busy_bad++;
            end
            if ((busy === 1'b1) && (busy_rise < 0)) busy_rise = i;
            if ((busy !== 1'b1) && (busy_rise >= 0) && (busy_fall < 0)) busy_fall = i;
            if (i == 7)  stepBtn = 1'b1;
            if (i == 20) stepBtn = 1'b0;
            if (i == 28) stepBtn = 1'b1;
        end
        check("burst_count", en_q.size(), BLEN);
        if (en_q.size() == BLEN) begin
            check("burst_gap1", en_q[1] - en_q[0], RM0 + 1);
            check("burst_gap2", en_q[2] - en_q[1], RM0 + 1);
            check("burst_busy_fall", busy_fall, en_q[BLEN-1] + 1);
        end
        check("burst_busy_rise", busy_rise, 3 + DEB);
        check("burst_busy_at_en", busy_bad, 0);

        // Reset in the middle of a burst.
        repeat ($urandom_range(9, 0)) step();
        stepBtn = 1'b0;
        d = -1;
        for (int i = 1; i <= 40; i++) begin
            if (d < 0) begin
                step();
                if (i == 7) stepBtn = 1'b1;
                if (cpuClkEn === 1'b1) d = i;
            end
        end
        stepBtn = 1'b1;
        check("rst_burst_started", int'(d > 0), 1);
        repeat (2) step();
        check("rst_busy_before", int'(busy), 1);
        nrst = 1'b0;
        #1;
        check("rst_async_en", int'(cpuClkEn), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_halted", int'(halted), 0);
        repeat (3) step();
        nrst = 1'b1;
        cnt = 0; busy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
            if (busy === 1'b1) busy_bad++;
        end
        check("rst_after_no_en", cnt, 0);
        check("rst_after_no_busy", busy_bad, 0);

        // Breakpoint at PC 5 in FULL mode.
        pcAddr = 12'h000;
        bpAddr = 12'h005;
        bpEn   = 1'b1;
        modeSel = 2'b11;
        cnt = 0; halt_at = -1; pc5_at = -1; post_en = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
            if ((pcAddr == 12'h005) && (pc5_at < 0)) pc5_at = i;
            if ((halted === 1'b1) && (halt_at < 0)) halt_at = i;
            if ((halted === 1'b1) && (cpuClkEn === 1'b1)) post_en++;
        end
`ifdef CLKCTRL_BREAKPOINT_EN
        check("bp_halt_cycle", halt_at, pc5_at + 1);
        check("bp_pc_range", int'((pcAddr >= 12'h005) && (pcAddr <= 12'h006)), 1);
        check("bp_no_en_halted", post_en, 0);
        // Mode/rate changes and clearing bpEn do not leave HALT.
        modeSel = 2'b10;
        rateSel = 2'd2;
        cnt = 0; not_halt = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
            if (halted !== 1'b1) not_halt++;
        end
        bpEn = 1'b0;
        modeSel = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
            if (halted !== 1'b1) not_halt++;
        end
        check("halt_hold_no_en", cnt, 0);
        check("halt_hold_halted", not_halt, 0);
        // A press steps over with exactly one enable.
        cnt = 0;
        stepBtn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cpuClkEn === 1'b1) cnt++;
        end
        stepBtn = 1'b1;
        check("halt_press_one_en", cnt, 1);
        check("halt_press_resumed", int'(halted), 0);
`else
        check("nobp_never_halted", halt_at, -1);
        check("nobp_en_continue", cnt, 30);
        check("nobp_pc", int'(pcAddr), 29);
`endif
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
